imem_loader: RTL and testbench

Writer side of the instruction memory. Receives a program as a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and issues word-aligned writes into instruction memory. Holds the processor in reset while loading, so the core fetches from PC 0 only after a complete image is in place.

---
 rtl/imem_loader.sv | 156 +++++++++++++++
 tb/tb_imem_loader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
//
// Takes a program as a byte stream over a valid/ready handshake and packs
// every four bytes into one little-endian 32-bit instruction word. Each
// finished word is written to instruction memory at a word-aligned byte
// address, starting at 0. The processor is held in reset for the whole load
// session, so it fetches from PC 0 only after the complete image is in place.
//
// Parameters:
//   DEPTH      instruction memory size in 32-bit words
//   ADDR_W     word index width, log2(DEPTH)
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   start       one-cycle request to begin a load; sampled only when idle
//   word_count  number of words to load, latched on an accepted start
//   rx_data     program byte
//   rx_valid    rx_data is valid
//   rx_ready    loader accepts a byte this cycle
//   mem_we      one-cycle instruction memory write strobe
//   mem_addr    byte address of the write (always a multiple of 4)
//   mem_wdata   instruction word being written
//   cpu_hold    keeps the processor in reset while a session is active
//   busy        high whenever the loader is not idle
//   done        one-cycle pulse when a session completes
//   err         one-cycle pulse when a start request is rejected
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE       = (ADDR_W + 1)'(1);

  state_t            state;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] word_last;   // index of the final word of the session
  logic [1:0]        byte_idx;
  logic [23:0]       byte_buf;    // bytes 0..2 of the word being assembled
  logic              count_ok;
  logic              byte_acc;

  assign count_ok = (word_count != '0) && (word_count <= MAX_COUNT);
  assign byte_acc = rx_valid && rx_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      word_idx  <= '0;
      word_last <= '0;
      byte_idx  <= '0;
      byte_buf  <= '0;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // Strobes default low; address and data hold their last written value.
      mem_we <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            if (count_ok) begin
              // Store the last index rather than the count so the WRITE
              // state needs only an equality compare against word_idx.
              word_last <= ADDR_W'(word_count - ONE);
              word_idx  <= '0;
              byte_idx  <= '0;
              state     <= COLLECT;
              rx_ready  <= 1'b1;
              cpu_hold  <= 1'b1;
              busy      <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end

        COLLECT: begin
          if (byte_acc) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: byte_buf[7:0]   <= rx_data;
              2'd1: byte_buf[15:8]  <= rx_data;
              2'd2: byte_buf[23:16] <= rx_data;
              default: begin
                // Fourth byte goes straight into the top lane of the write.
                mem_we    <= 1'b1;
                mem_addr  <= {{(30 - ADDR_W){1'b0}}, word_idx, 2'b00};
                mem_wdata <= {rx_data, byte_buf};
                rx_ready  <= 1'b0;
                state     <= WRITE;
              end
            endcase
          end
        end

        WRITE: begin
          word_idx <= word_idx + ADDR_W'(1);
          byte_idx <= '0;
          if (word_idx == word_last) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state    <= COLLECT;
            rx_ready <= 1'b1;
          end
        end

        DONE: begin
          state    <= IDLE;
          cpu_hold <= 1'b0;
          busy     <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          rx_ready <= 1'b0;
          cpu_hold <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: drives byte streams with optional gaps and compares
// the observed memory writes against the image the byte stream describes.
module tb_imem_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- monitor (sampled on the falling edge) ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } wr_t;

  wr_t         wr_q[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          err_cnt = 0;
  int          overlap_viol = 0;
  int          we_long = 0;
  int          rdy_idle_viol = 0;
  int          hold_viol = 0;
  int          keep_viol = 0;
  logic        we_prev = 1'b0;
  logic [31:0] last_a = '0;
  logic [31:0] last_d = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_q.push_back('{mem_addr, mem_wdata, cyc});
      if (we_prev) we_long <= we_long + 1;
    end
    we_prev <= mem_we;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (err) err_cnt <= err_cnt + 1;
    if (err && done) overlap_viol <= overlap_viol + 1;
    if (rx_ready && !busy) rdy_idle_viol <= rdy_idle_viol + 1;
    if ((cpu_hold !== busy) || (done && !cpu_hold)) hold_viol <= hold_viol + 1;
    if (reset && !mem_we && (mem_addr !== last_a || mem_wdata !== last_d))
      keep_viol <= keep_viol + 1;
    if (!reset) begin
      last_a <= '0;
      last_d <= '0;
    end else if (mem_we) begin
      last_a <= mem_addr;
      last_d <= mem_wdata;
    end
  end

  // ---------------- stimulus helpers ----------------
  int s_cyc;

  task automatic do_start(input int w);
    start      = 1'b1;
    word_count = (ADDR_W + 1)'(w);
    @(posedge clk); #1;
    start = 1'b0;
    s_cyc = cyc;
  endtask

  // gap < 0 selects a random gap of 0..3 idle cycles after each byte
  task automatic send_bytes(input logic [7:0] q[$], input int gap);
    foreach (q[i]) begin
      int t;
      int g;
      bit acc;
      t   = 0;
      acc = 1'b0;
      rx_data  = q[i];
      rx_valid = 1'b1;
      while (!acc && t < 200) begin
        @(negedge clk);
        acc = rx_ready;
        @(posedge clk); #1;
        t++;
      end
      if (!acc) begin
        check("rx_accept_timeout", 32'd0, 32'd1);
        rx_valid = 1'b0;
        return;
      end
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      if (g > 0) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (g) @(posedge clk);
        #1;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < limit);
    check("idle_reached", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  // Reference: word i is bytes 4i..4i+3 little-endian, written at 4*i.
  task automatic run_session(input string name, input logic [7:0] q[$], input int w,
                             input int gap, input bit timing);
    int wbase;
    int dbase;
    int ebase;
    wbase = wr_q.size();
    dbase = done_cnt;
    ebase = err_cnt;
    do_start(w);
    send_bytes(q, gap);
    wait_idle(3000);
    check({name, "_nwrites"}, 32'(wr_q.size() - wbase), 32'(w));
    check({name, "_ndone"}, 32'(done_cnt - dbase), 32'd1);
    check({name, "_nerr"}, 32'(err_cnt - ebase), 32'd0);
    for (int i = 0; i < w; i++) begin
      if (wbase + i < wr_q.size()) begin
        logic [31:0] exp_w;
        exp_w = {q[4*i+3], q[4*i+2], q[4*i+1], q[4*i]};
        check($sformatf("%s_addr%0d", name, i), wr_q[wbase+i].a, 32'(4 * i));
        check($sformatf("%s_data%0d", name, i), wr_q[wbase+i].d, exp_w);
      end
    end
    if (wr_q.size() > wbase) begin
      check({name, "_done_after_last"}, 32'(done_cyc - wr_q[wr_q.size()-1].c), 32'd1);
      if (timing) begin
        check({name, "_first_we_lat"}, 32'(wr_q[wbase].c - s_cyc), 32'd4);
        check({name, "_done_lat"}, 32'(done_cyc - s_cyc), 32'(5 * w));
      end
    end
  endtask

  task automatic reject(input string name, input int w);
    int wbase;
    wbase = wr_q.size();
    do_start(w);
    @(negedge clk);
    check({name, "_err"}, 32'(err), 32'd1);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_hold"}, 32'(cpu_hold), 32'd0);
    @(negedge clk);
    check({name, "_err_1cyc"}, 32'(err), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check({name, "_nowrite"}, 32'(wr_q.size() - wbase), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] img[$];
    int w;
    int wbase;

    reset      = 1'b0;
    start      = 1'b1;
    word_count = 7'd2;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;

    // Reset held with start asserted: everything stays cleared.
    repeat (2) @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    start = 1'b0;
    rx_valid = 1'b1;   // bytes offered in IDLE must not be taken
    repeat (2) @(negedge clk);
    check("post_rst_rx_ready", 32'(rx_ready), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rx_valid = 1'b0;

    // Two-word load, continuous valid.
    img = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'hB3, 8'h00, 8'h52, 8'h00};
    run_session("two_word", img, 2, 0, 1'b1);

    // Same image with three idle cycles between bytes.
    run_session("backpressure", img, 2, 3, 1'b0);

    // Rejected starts.
    reject("rej_zero", 0);
    reject("rej_65", 65);

    // Reset after two bytes of the second word.
    wbase = wr_q.size();
    do_start(2);
    img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_bytes(img, 0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hold", 32'(cpu_hold), 32'd0);
    check("midrst_rx_ready", 32'(rx_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_nwrites", 32'(wr_q.size() - wbase), 32'd1);
    if (wr_q.size() > wbase)
      check("midrst_word0", wr_q[wbase].d, 32'h44332211);
    check("midrst_idle", 32'(busy), 32'd0);
    img = '{8'h93, 8'h00, 8'h10, 8'h00};
    run_session("after_rst", img, 1, 0, 1'b1);

    // Full depth with a stray start mid-session.
    img = {};
    for (int i = 0; i < 4 * DEPTH; i++) img.push_back(8'($urandom));
    fork
      run_session("full", img, DEPTH, 0, 1'b1);
      begin
        repeat (40) @(posedge clk);
        #2;
        start      = 1'b1;
        word_count = 7'd5;
        @(posedge clk); #2;
        start = 1'b0;
      end
    join

    // Randomized sessions with random gaps.
    for (int r = 0; r < 4; r++) begin
      w = int'($urandom_range(1, 8));
      img = {};
      for (int i = 0; i < 4 * w; i++) img.push_back(8'($urandom));
      run_session($sformatf("rand%0d", r), img, w, (r == 0) ? 0 : -1, r == 0);
    end

    check("err_done_overlap", 32'(overlap_viol), 32'd0);
    check("mem_we_one_cycle", 32'(we_long), 32'd0);
    check("rx_ready_when_idle", 32'(rdy_idle_viol), 32'd0);
    check("cpu_hold_window", 32'(hold_viol), 32'd0);
    check("addr_data_hold", 32'(keep_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
